mem_fill_arbiter: RTL and testbench

//  Arbitrates the I-cache and D-cache for the single main-memory port. Performs
//  8-word cache-block fills on a miss and single-word write-through stores.

---
 rtl/mem_fill_arbiter_if.sv | 47 ++++
 rtl/mem_fill_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_fill_arbiter_if.sv
// Cache/memory side bundle of the fill arbiter: both cache request paths,
// the shared memory port and the fill strobes back to the caches.
interface mem_fill_arbiter_if #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int WORD_W      = $clog2(BLOCK_WORDS)
);
    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              d_wr_ack;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] fill_data;
    logic [WORD_W-1:0] fill_word;
    logic              i_fill_we;
    logic              d_fill_we;
    logic              i_filling;
    logic              d_filling;
    logic              i_fill_done;
    logic              d_fill_done;

    modport slave (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        output d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, i_fill_we, d_fill_we,
        output i_filling, d_filling, i_fill_done, d_fill_done
    );

    modport master (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        input  d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, i_fill_we, d_fill_we,
        input  i_filling, d_filling, i_fill_done, d_fill_done
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares one main-memory port between I-cache and D-cache: pipelined block
// fills on a miss and single-cycle write-through stores.
module mem_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_fill_arbiter_if.slave    bus
);
    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W  = WORD_W + 1;
    localparam logic [OFF_W-1:0]  BLOCK_CNT = OFF_W'(BLOCK_WORDS);
    localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(2 * BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              src_d_r;
    logic [ADDR_W-1:0] base_r;
    logic [OFF_W-1:0]  iss_cnt_r;
    logic [OFF_W-1:0]  rcv_cnt_r;
    logic              issue_s;
    logic              recv_s;
    logic              last_s;
    logic              start_fill_s;

    // Fill issue/receive qualifiers; a return is only accepted for a word already issued
    always_comb begin
        issue_s = 1'b0;
        recv_s  = 1'b0;
        if (state_r == FILL) begin
            issue_s = (iss_cnt_r < BLOCK_CNT);
            recv_s  = bus.mem_rvalid && (rcv_cnt_r < iss_cnt_r);
        end else begin
            issue_s = 1'b0;
            recv_s  = 1'b0;
        end
        last_s       = recv_s && (rcv_cnt_r == LAST_WORD);
        start_fill_s = (state_r == IDLE) && !bus.d_wr && (bus.d_miss || bus.i_miss);
    end

    // Next-state logic: store beats D miss beats I miss, and only from IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.d_wr) begin
                    state_s = WRITE;
                end else if (bus.d_miss || bus.i_miss) begin
                    state_s = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: state_s = IDLE;
            FILL: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = FILL;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, source/base capture and issue/receive counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            src_d_r   <= 1'b0;
            base_r    <= '0;
            iss_cnt_r <= '0;
            rcv_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if (start_fill_s) begin
                src_d_r <= bus.d_miss;
                base_r  <= (bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr) & ~OFF_MASK;
            end
            if (state_r == DONE) begin
                iss_cnt_r <= '0;
                rcv_cnt_r <= '0;
            end else begin
                if (issue_s) iss_cnt_r <= iss_cnt_r + OFF_W'(1);
                if (recv_s)  rcv_cnt_r <= rcv_cnt_r + OFF_W'(1);
            end
        end
    end

    assign bus.fill_data = bus.mem_rdata;

    // Output decode; fill write-enables follow mem_rvalid in the same cycle
    always_comb begin
        bus.d_wr_ack    = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.fill_word   = '0;
        bus.i_fill_we   = 1'b0;
        bus.d_fill_we   = 1'b0;
        bus.i_filling   = 1'b0;
        bus.d_filling   = 1'b0;
        bus.i_fill_done = 1'b0;
        bus.d_fill_done = 1'b0;
        case (state_r)
            IDLE: bus.mem_en = 1'b0;
            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = bus.d_wr_addr;
                bus.mem_wdata = bus.d_wr_data;
                bus.d_wr_ack  = 1'b1;
            end
            FILL: begin
                bus.i_filling = !src_d_r;
                bus.d_filling = src_d_r;
                if (issue_s) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = base_r | ADDR_W'({iss_cnt_r[WORD_W-1:0], 1'b0});
                end else begin
                    bus.mem_en   = 1'b0;
                end
                if (recv_s) begin
                    bus.fill_word = rcv_cnt_r[WORD_W-1:0];
                    bus.i_fill_we = !src_d_r;
                    bus.d_fill_we = src_d_r;
                end else begin
                    bus.fill_word = '0;
                end
            end
            DONE: begin
                bus.i_fill_done = !src_d_r;
                bus.d_fill_done = src_d_r;
            end
            default: bus.mem_en = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a 4-cycle-latency memory model whose
// read data is the word address XOR 16'hA5A5.
module tb_mem_fill_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_fill_arbiter_if bus ();

    mem_fill_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: in-order reads, fixed latency of 4 cycles, plus an injectable stale pulse
    logic [3:0]  pv = 4'b0000;
    logic [15:0] pa [0:3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        inj = 1'b0;
    always_ff @(posedge clk) begin
        pv    <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
        pa[0] <= bus.mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign bus.mem_rvalid = pv[3] | inj;
    assign bus.mem_rdata  = pa[3] ^ 16'hA5A5;

    logic        r_en   [0:47];
    logic        r_wr   [0:47];
    logic [15:0] r_addr [0:47];
    logic [15:0] r_wdat [0:47];
    logic        r_ack  [0:47];
    logic        r_iwe  [0:47];
    logic        r_dwe  [0:47];
    logic [2:0]  r_word [0:47];
    logic [15:0] r_fdat [0:47];
    logic        r_ifl  [0:47];
    logic        r_dfl  [0:47];
    logic        r_idn  [0:47];
    logic        r_ddn  [0:47];
    int wr_at, rst_at, rst_rel_at, inj_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Samples n cycles at negedges (index 1 = cycle after request) and plays cache reactions
    task automatic record(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            r_en[k] = bus.mem_en;      r_wr[k] = bus.mem_wr;
            r_addr[k] = bus.mem_addr;  r_wdat[k] = bus.mem_wdata;
            r_ack[k] = bus.d_wr_ack;   r_iwe[k] = bus.i_fill_we;
            r_dwe[k] = bus.d_fill_we;  r_word[k] = bus.fill_word;
            r_fdat[k] = bus.fill_data; r_ifl[k] = bus.i_filling;
            r_dfl[k] = bus.d_filling;  r_idn[k] = bus.i_fill_done;
            r_ddn[k] = bus.d_fill_done;
            if (bus.i_fill_done) bus.i_miss = 1'b0;
            if (bus.d_fill_done) bus.d_miss = 1'b0;
            if (bus.d_wr_ack)    bus.d_wr = 1'b0;
            if (k == wr_at) begin
                bus.d_wr = 1'b1; bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF;
            end
            if (k == rst_at) begin
                rst = 1'b1; bus.i_miss = 1'b0; bus.d_miss = 1'b0;
            end
            if (k == rst_rel_at) rst = 1'b0;
            inj = (k == inj_at);
        end
        wr_at = 0; rst_at = 0; rst_rel_at = 0; inj_at = 0; inj = 1'b0;
    endtask

    // Expected block-fill pattern for a request seen in IDLE at recorded cycle t0
    task automatic check_fill(input int t0, input logic [15:0] base, input logic is_d);
        for (int j = 1; j <= 13; j++) begin
            int k = t0 + j;
            logic en_e, we_e;
            en_e = (j <= 8);
            we_e = (j >= 5) && (j <= 12);
            chk($sformatf("fill_en c%0d", k), 32'(r_en[k]), 32'(en_e));
            if (en_e) begin
                chk($sformatf("fill_rd c%0d", k), 32'(r_wr[k]), 32'd0);
                chk($sformatf("fill_addr c%0d", k), 32'(r_addr[k]), 32'(base + 16'(2 * (j - 1))));
            end
            chk($sformatf("i_we c%0d", k), 32'(r_iwe[k]), 32'(we_e & ~is_d));
            chk($sformatf("d_we c%0d", k), 32'(r_dwe[k]), 32'(we_e & is_d));
            if (we_e) begin
                chk($sformatf("word c%0d", k), 32'(r_word[k]), 32'(j - 5));
                chk($sformatf("fdata c%0d", k), 32'(r_fdat[k]),
                    32'((base + 16'(2 * (j - 5))) ^ 16'hA5A5));
            end
            chk($sformatf("i_filling c%0d", k), 32'(r_ifl[k]), 32'((j <= 12) & ~is_d));
            chk($sformatf("d_filling c%0d", k), 32'(r_dfl[k]), 32'((j <= 12) & is_d));
            chk($sformatf("i_done c%0d", k), 32'(r_idn[k]), 32'((j == 13) & ~is_d));
            chk($sformatf("d_done c%0d", k), 32'(r_ddn[k]), 32'((j == 13) & is_d));
        end
    endtask

    initial begin
        wr_at = 0; rst_at = 0; rst_rel_at = 0; inj_at = 0;
        bus.i_miss = 1'b0; bus.i_miss_addr = '0;
        bus.d_miss = 1'b0; bus.d_miss_addr = '0;
        bus.d_wr = 1'b0;   bus.d_wr_addr = '0; bus.d_wr_data = '0;

        // Reset held two cycles, then idle with no requests
        @(negedge clk);
        @(negedge clk);
        chk("rst mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst ack", 32'(bus.d_wr_ack), 32'd0);
        chk("rst we", 32'({bus.i_fill_we, bus.d_fill_we}), 32'd0);
        chk("rst filling", 32'({bus.i_filling, bus.d_filling}), 32'd0);
        chk("rst done", 32'({bus.i_fill_done, bus.d_fill_done}), 32'd0);
        chk("rst fill_word", 32'(bus.fill_word), 32'd0);
        chk("rst fill_data", 32'(bus.fill_data), 32'(pa[3] ^ 16'hA5A5));
        rst = 1'b0;
        record(4);
        for (int k = 1; k <= 4; k++) chk($sformatf("idle en c%0d", k), 32'(r_en[k]), 32'd0);

        // Single I-cache fill
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1236;
        record(14);
        check_fill(0, 16'h1230, 1'b0);
        chk("i fill back idle", 32'(r_en[14]), 32'd0);

        // Simultaneous misses: D first, then I
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1236;
        bus.d_miss = 1'b1; bus.d_miss_addr = 16'h0A04;
        record(28);
        check_fill(0, 16'h0A00, 1'b1);
        chk("dual gap en c14", 32'(r_en[14]), 32'd0);
        check_fill(14, 16'h1230, 1'b0);

        // Store raised during an I fill waits for IDLE
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1236;
        wr_at = 3;
        record(17);
        check_fill(0, 16'h1230, 1'b0);
        for (int k = 1; k <= 14; k++) chk($sformatf("wr wait ack c%0d", k), 32'(r_ack[k]), 32'd0);
        chk("wr en", 32'(r_en[15]), 32'd1);
        chk("wr wr", 32'(r_wr[15]), 32'd1);
        chk("wr addr", 32'(r_addr[15]), 32'h0040);
        chk("wr data", 32'(r_wdat[15]), 32'hBEEF);
        chk("wr ack", 32'(r_ack[15]), 32'd1);
        chk("wr after en", 32'(r_en[16]), 32'd0);

        // Store and D miss in the same IDLE cycle: store first
        bus.d_wr = 1'b1; bus.d_wr_addr = 16'h0100; bus.d_wr_data = 16'h1234;
        bus.d_miss = 1'b1; bus.d_miss_addr = 16'h3008;
        record(16);
        chk("st1 en", 32'(r_en[1]), 32'd1);
        chk("st1 wr", 32'(r_wr[1]), 32'd1);
        chk("st1 addr", 32'(r_addr[1]), 32'h0100);
        chk("st1 data", 32'(r_wdat[1]), 32'h1234);
        chk("st1 ack", 32'(r_ack[1]), 32'd1);
        chk("st1 dfill", 32'(r_dfl[1]), 32'd0);
        chk("st1 idle en", 32'(r_en[2]), 32'd0);
        check_fill(2, 16'h3000, 1'b1);

        // Reset after the third fill word; trailing returns must be ignored
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1236;
        rst_at = 7; rst_rel_at = 8; inj_at = 11;
        record(16);
        chk("abort 3rd we", 32'(r_iwe[7]), 32'd1);
        chk("abort 3rd word", 32'(r_word[7]), 32'd2);
        for (int k = 8; k <= 16; k++) begin
            chk($sformatf("abort en c%0d", k), 32'(r_en[k]), 32'd0);
            chk($sformatf("abort we c%0d", k), 32'({r_iwe[k], r_dwe[k]}), 32'd0);
            chk($sformatf("abort fl c%0d", k), 32'({r_ifl[k], r_dfl[k]}), 32'd0);
            chk($sformatf("abort dn c%0d", k), 32'({r_idn[k], r_ddn[k]}), 32'd0);
        end

        // Fresh fill after the abort starts from word 0
        bus.d_miss = 1'b1; bus.d_miss_addr = 16'h0A04;
        record(14);
        check_fill(0, 16'h0A00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
